// File: rtl/instr_queue_pkg.sv
// Shared definitions for the instruction queue and its downstream controller:
// instruction width, opcode field, legal opcodes and the controller wait state.
package instr_queue_pkg;
  localparam int FUNC_W = 25;
  localparam int OP_MSB = 24;
  localparam int OP_LSB = 22;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;

  localparam logic [4:0] CTRL_WAIT = 5'b00001;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {OP_LOAD, OP_MOVE, OP_ADD, OP_XOR};
  endfunction
endpackage

// File: rtl/instr_queue_if.sv
// Producer/issue signal bundle of the instruction queue; slave is the queue side.
interface instr_queue_if #(
  parameter int DEPTH  = 4,
  parameter int FUNC_W = instr_queue_pkg::FUNC_W
);
  logic                       in_valid;
  logic                       in_ready;
  logic [FUNC_W-1:0]          in_instr;
  logic                       flush;
  logic                       ctrl_idle;
  logic [FUNC_W-1:0]          func;
  logic                       new_func;
  logic [$clog2(DEPTH):0]     count;
  logic                       drop_err;

  modport master (
    output in_valid, in_instr, flush, ctrl_idle,
    input  in_ready, func, new_func, count, drop_err
  );

  modport slave (
    input  in_valid, in_instr, flush, ctrl_idle,
    output in_ready, func, new_func, count, drop_err
  );
endinterface

// File: rtl/instr_fifo_mem.sv
// Instruction storage: DEPTH x FUNC_W registers, sync write, async read.
// Latency: write visible on read port after the write edge. No backpressure; no reset.
module instr_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int FUNC_W = 25,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FUNC_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FUNC_W-1:0] rdata
);
  logic [FUNC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// Instruction queue: filters illegal opcodes, issues one entry per idle controller slot.
// Latency: accepted entry issues at the second edge earliest. Backpressure: in_ready low when full or flushing.
// Issue spacing is at least two cycles because the strobe itself blocks the next issue.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FUNC_W = instr_queue_pkg::FUNC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [FUNC_W-1:0] func, rd_data;
  logic              new_func, drop_err;
  logic              push, legal, wr_en, issue;

  assign q.in_ready = (count < FULL) && !q.flush && rst_n;
  assign push       = q.in_valid && q.in_ready;
  assign legal      = op_legal(q.in_instr[OP_MSB:OP_LSB]);
  assign wr_en      = push && legal;
  assign issue      = (count != '0) && q.ctrl_idle && !new_func && !q.flush;

  instr_fifo_mem #(.DEPTH(DEPTH), .FUNC_W(FUNC_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (q.in_instr),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      func     <= '0;
      new_func <= 1'b0;
      drop_err <= 1'b0;
    end else if (q.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      func     <= '0;
      new_func <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + PW'(1);
        func   <= rd_data;
      end
      new_func <= issue;
      drop_err <= push && !legal;
      // Simultaneous push and issue cancel out in the count.
      case ({wr_en, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign q.func     = func;
  assign q.new_func = new_func;
  assign q.count    = count;
  assign q.drop_err = drop_err;
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-002 SHALL have parameter FUNC_W, default 25, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer presents in_instr.
REQ-006 SHALL have port in_ready  output  1  queue accepts in_instr this cycle.
REQ-007 SHALL have port in_instr  input  FUNC_W  instruction; opcode field [24:22].
REQ-008 SHALL have port flush  input  1  synchronous discard of all queued entries.
REQ-009 SHALL have port ctrl_idle  input  1  downstream controller is in its wait state (5'b00001).
REQ-010 SHALL have port func  output  FUNC_W  issued instruction, registered.
REQ-011 SHALL have port new_func  output  1  one-cycle issue strobe, registered.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries, registered.
REQ-013 SHALL have port drop_err  output  1  one-cycle pulse: illegal opcode discarded.

Function
REQ-014 Legal opcodes SHALL be 3'b000 LOAD, 3'b001 MOVE, 3'b010 ADD, 3'b011 XOR; 3'b1xx is illegal.
REQ-015 in_ready SHALL equal (count < DEPTH) && !flush && rst_n; it is computed from registered count only (no same-cycle pop credit).
REQ-016 A transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 A legal transfer SHALL write in_instr at the write pointer, advance it modulo DEPTH and increment count.
REQ-018 An illegal transfer SHALL complete the handshake, store nothing, leave count unchanged, and assert drop_err for exactly the following cycle.
REQ-019 Issue condition, evaluated each edge: count > 0 && ctrl_idle && !new_func && !flush.
REQ-020 On issue SHALL load func with the head entry, assert new_func for exactly one cycle, advance the read pointer modulo DEPTH and decrement count.
REQ-021 func SHALL hold its value until the next issue or flush; it does not return to 0 after new_func falls.
REQ-022 The !new_func term SHALL prevent double issue while ctrl_idle stays high during the strobe cycle; minimum issue spacing is 2 cycles.
REQ-023 Latency: entry accepted at edge k into empty queue with ctrl_idle high SHALL raise new_func after edge k+1; no write-to-issue bypass.
REQ-024 Simultaneous legal push and issue SHALL leave count unchanged and update both pointers.
REQ-025 Entries SHALL issue in strict acceptance order.
REQ-026 flush SHALL on the next edge zero both pointers and count, clear func to 0 and new_func to 0, suppress any push, issue or drop_err in that cycle, and take priority over all other events.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 While rst_n is low: func=0, new_func=0, count=0, drop_err=0, in_ready=0, pointers=0.
REQ-029 Storage array contents SHALL NOT be reset; only entries within count are observable.
REQ-030 Reset asserted mid-operation SHALL discard all entries, including any strobe in flight, immediately and without waiting for clk.
REQ-031 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package SHALL hold FUNC_W, the opcode field bounds (24:22), constants OP_LOAD/OP_MOVE/OP_ADD/OP_XOR, and the controller wait-state encoding 5'b00001; both this block and the controller SHALL use the package.
REQ-033 Storage SHALL be one sub-module, instr_fifo_mem: DEPTH x FUNC_W register array, one synchronous write port, one asynchronous read port.
REQ-034 Pointer, count and issue logic SHALL live in instr_queue; the sub-module has no reset.

Verification
REQ-035 Reset, ctrl_idle=1, push ADD 25'h0800001 at edge 1 -> new_func high after edge 2, func=25'h0800001, count back to 0.
REQ-036 ctrl_idle=0, push 5 legal instructions back-to-back with DEPTH=4 -> 4 accepted, in_ready=0 with count=4, 5th held until ctrl_idle=1 frees a slot.
REQ-037 Push 3'b111 opcode (25'h1C00000) -> handshake completes, count unchanged, drop_err pulses one cycle, no new_func.
REQ-038 ctrl_idle held at 1, queue holds LOAD,MOVE,XOR -> three single-cycle new_func strobes 2 cycles apart, in acceptance order.
REQ-039 count=3, assert flush together with in_valid and ctrl_idle -> next cycle count=0, func=0, new_func=0, nothing accepted or issued.
REQ-040 Assert rst_n low asynchronously while new_func=1 and count=2 -> outputs zero before next clk edge; queue empty after release.
